// File: rtl/framebuffer_arbiter_if.sv
// rtl/framebuffer_arbiter_if.sv - pixel read, edge-pipeline write and shared SPRAM bus bundle
interface framebuffer_arbiter_if;
    logic        rdReq;
    logic [15:0] rdAddr;
    logic [1:0]  rdData;
    logic        rdValid;
    logic        wrValid;
    logic        wrReady;
    logic [15:0] wrAddr;
    logic [1:0]  wrData;
    logic [13:0] ramAddr;
    logic [2:0]  ramCs;
    logic        ramWe;
    logic [3:0]  ramMaskWe;
    logic [15:0] ramDi;
    logic [15:0] ramDo0;
    logic [15:0] ramDo1;
    logic [15:0] ramDo2;
    logic [2:0]  fifoLevel;
    logic [7:0]  dropCnt;
    logic        starveErr;

    modport slave (
        input  rdReq, rdAddr, wrValid, wrAddr, wrData, ramDo0, ramDo1, ramDo2,
        output rdData, rdValid, wrReady, ramAddr, ramCs, ramWe, ramMaskWe, ramDi,
               fifoLevel, dropCnt, starveErr
    );

    modport master (
        output rdReq, rdAddr, wrValid, wrAddr, wrData, ramDo0, ramDo1, ramDo2,
        input  rdData, rdValid, wrReady, ramAddr, ramCs, ramWe, ramMaskWe, ramDi,
               fifoLevel, dropCnt, starveErr
    );
endinterface

// File: rtl/framebuffer_arbiter.sv
// rtl/framebuffer_arbiter.sv - read-priority arbiter sharing three SPRAM banks between VGA reads and queued writes
module framebuffer_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                 mainClk,
    input  logic                 rst,
    framebuffer_arbiter_if.slave fb
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [15:0]   qAddr [FIFO_DEPTH];
    logic [1:0]    qData [FIFO_DEPTH];
    logic [PW-1:0] wPtr;
    logic [PW-1:0] rPtr;
    logic [LW-1:0] level;
    logic [SW-1:0] starveCnt;

    logic        rd1Valid, rd2Valid;
    logic [1:0]  rd1Bank, rd2Bank;
    logic [1:0]  rdDataR;
    logic        rdValidR;
    logic [13:0] ramAddrR;
    logic [2:0]  ramCsR;
    logic        ramWeR;
    logic [3:0]  ramMaskWeR;
    logic [15:0] ramDiR;
    logic [7:0]  dropCntR;
    logic        starveErrR;

    logic wrReady, accept, isDrop, push, pop, fifoBusy;

    function automatic logic [2:0] bank_sel(input logic [1:0] bank);
        case (bank)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            2'd2:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // wrReady looks only at the registered level, so a full queue never takes a write even while popping
    assign fifoBusy = (level != '0);
    assign wrReady  = (level < LW'(FIFO_DEPTH));
    assign accept   = fb.wrValid & wrReady;
    assign isDrop   = accept & (fb.wrAddr[15:14] == 2'b11);
    assign push     = accept & ~isDrop;
    assign pop      = ~fb.rdReq & fifoBusy;

    always_ff @(posedge mainClk) begin
        if (push) begin
            qAddr[wPtr] <= fb.wrAddr;
            qData[wPtr] <= fb.wrData;
        end
    end

    always_ff @(posedge mainClk) begin
        if (rst) begin
            wPtr       <= '0;
            rPtr       <= '0;
            level      <= '0;
            starveCnt  <= '0;
            starveErrR <= 1'b0;
            dropCntR   <= 8'd0;
            ramAddrR   <= 14'd0;
            ramCsR     <= 3'b000;
            ramWeR     <= 1'b0;
            ramMaskWeR <= 4'b0000;
            ramDiR     <= 16'd0;
            rd1Valid   <= 1'b0;
            rd2Valid   <= 1'b0;
            rd1Bank    <= 2'b00;
            rd2Bank    <= 2'b00;
            rdValidR   <= 1'b0;
            rdDataR    <= 2'b00;
        end else begin
            if (push) wPtr <= wPtr + PW'(1);
            if (pop)  rPtr <= rPtr + PW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase

            if (isDrop && dropCntR != 8'hFF) dropCntR <= dropCntR + 8'd1;

            // Only cycles where a read actually blocks a pending write count toward starvation
            if (fb.rdReq && fifoBusy) begin
                if (starveCnt != SW'(STARVE_LIMIT)) starveCnt <= starveCnt + SW'(1);
                if (starveCnt == SW'(STARVE_LIMIT - 1)) starveErrR <= 1'b1;
            end else begin
                starveCnt <= '0;
            end

            if (fb.rdReq) begin
                ramAddrR   <= fb.rdAddr[13:0];
                ramCsR     <= bank_sel(fb.rdAddr[15:14]);
                ramWeR     <= 1'b0;
                ramMaskWeR <= 4'b0000;
            end else if (fifoBusy) begin
                ramAddrR   <= qAddr[rPtr][13:0];
                ramCsR     <= bank_sel(qAddr[rPtr][15:14]);
                ramWeR     <= 1'b1;
                ramMaskWeR <= 4'b0001;
                ramDiR     <= {14'd0, qData[rPtr]};
            end else begin
                ramCsR     <= 3'b000;
                ramWeR     <= 1'b0;
                ramMaskWeR <= 4'b0000;
            end

            // Bank 3 reads travel the pipeline too and come back as zero
            rd1Valid <= fb.rdReq;
            rd1Bank  <= fb.rdAddr[15:14];
            rd2Valid <= rd1Valid;
            rd2Bank  <= rd1Bank;
            rdValidR <= rd2Valid;
            if (rd2Valid) begin
                case (rd2Bank)
                    2'd0:    rdDataR <= fb.ramDo0[1:0];
                    2'd1:    rdDataR <= fb.ramDo1[1:0];
                    2'd2:    rdDataR <= fb.ramDo2[1:0];
                    default: rdDataR <= 2'b00;
                endcase
            end
        end
    end

    logic unused_ramdo;
    assign unused_ramdo = ^{fb.ramDo0[15:2], fb.ramDo1[15:2], fb.ramDo2[15:2]};

    assign fb.wrReady   = wrReady;
    assign fb.fifoLevel = 3'(level);
    assign fb.dropCnt   = dropCntR;
    assign fb.starveErr = starveErrR;
    assign fb.ramAddr   = ramAddrR;
    assign fb.ramCs     = ramCsR;
    assign fb.ramWe     = ramWeR;
    assign fb.ramMaskWe = ramMaskWeR;
    assign fb.ramDi     = ramDiR;
    assign fb.rdValid   = rdValidR;
    assign fb.rdData    = rdDataR;
endmodule
